// File: rtl/door_code_tx.sv
// Framed serial transmitter for the door-lock code: start bit, code MSB-first,
// optional even parity, then a forced-low gap. All outputs are registered.
module door_code_tx #(
  parameter int CODE_LEN   = 8,
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int PARITY_EN  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic                abort,
  output logic                tx_out,
  output logic                busy,
  output logic                done,
  output logic [2:0]          o_dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam int MAX_CYC = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int BW      = $clog2(CODE_LEN + 1);

  localparam logic [CW-1:0] BIT_RELOAD = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_RELOAD = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(CODE_LEN - 1);

  logic [2:0]          r_state;
  logic [CODE_LEN-1:0] r_shift;
  logic                r_parity;
  logic [BW-1:0]       r_bit;
  logic [CW-1:0]       r_cyc;
  logic                r_tx;
  logic                r_busy;
  logic                r_done;

  logic [CODE_LEN-1:0] w_shift_next;
  logic                w_cyc_last;

  assign w_shift_next = r_shift << 1;
  assign w_cyc_last   = (r_cyc == '0);

  // tx/busy are loaded with the level of the state being entered, so the
  // line changes exactly on the edge that starts each bit window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_bit    <= '0;
      r_cyc    <= '0;
      r_tx     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && abort) begin
        r_state <= S_IDLE;
        r_bit   <= '0;
        r_cyc   <= '0;
        r_tx    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state  <= S_START;
              r_shift  <= code;
              r_parity <= ^code;
              r_cyc    <= BIT_RELOAD;
              r_tx     <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
          S_START: begin
            if (w_cyc_last) begin
              r_state <= S_DATA;
              r_bit   <= LAST_BIT;
              r_cyc   <= BIT_RELOAD;
              r_tx    <= r_shift[CODE_LEN-1];
            end else begin
              r_cyc <= r_cyc - 1'b1;
            end
          end
          S_DATA: begin
            if (!w_cyc_last) begin
              r_cyc <= r_cyc - 1'b1;
            end else if (r_bit != '0) begin
              r_shift <= w_shift_next;
              r_bit   <= r_bit - 1'b1;
              r_cyc   <= BIT_RELOAD;
              r_tx    <= w_shift_next[CODE_LEN-1];
            end else if (PARITY_EN != 0) begin
              r_state <= S_PARITY;
              r_cyc   <= BIT_RELOAD;
              r_tx    <= r_parity;
            end else begin
              r_state <= S_GAP;
              r_cyc   <= GAP_RELOAD;
              r_tx    <= 1'b0;
            end
          end
          S_PARITY: begin
            if (w_cyc_last) begin
              r_state <= S_GAP;
              r_cyc   <= GAP_RELOAD;
              r_tx    <= 1'b0;
            end else begin
              r_cyc <= r_cyc - 1'b1;
            end
          end
          S_GAP: begin
            if (w_cyc_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cyc <= r_cyc - 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_out      = r_tx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_door_code_tx.sv
// Directed bench for door_code_tx: two configurations, per-cycle expected
// {busy,done,tx} words queued at frame request and checked one per cycle.
module tb_door_code_tx;

  localparam int A_BC = 2, A_GC = 3, A_PE = 1;
  localparam int B_BC = 1, B_GC = 3, B_PE = 0;
  localparam int A_N  = (1 + 8 + A_PE) * A_BC + A_GC;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] code = 8'h00;
  logic       abort = 1'b0;

  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;
  logic [2:0] st_a, st_b;

  logic [2:0] exp_q_a[$];
  logic [2:0] exp_q_b[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  door_code_tx #(.CODE_LEN(8), .BIT_CYCLES(A_BC), .GAP_CYCLES(A_GC), .PARITY_EN(A_PE)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .code(code), .abort(abort),
    .tx_out(tx_a), .busy(busy_a), .done(done_a), .o_dbg_state(st_a)
  );

  door_code_tx #(.CODE_LEN(8), .BIT_CYCLES(B_BC), .GAP_CYCLES(B_GC), .PARITY_EN(B_PE)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .code(code), .abort(abort),
    .tx_out(tx_b), .busy(busy_b), .done(done_b), .o_dbg_state(st_b)
  );

  // Expected line: start slot, data MSB-first, optional parity, gap, done cycle.
  task automatic push_frame(input bit sel_b, input logic [7:0] c);
    int bc, gc, pe;
    logic [2:0] w[$];
    bc = sel_b ? B_BC : A_BC;
    gc = sel_b ? B_GC : A_GC;
    pe = sel_b ? B_PE : A_PE;
    for (int k = 0; k < bc; k++) w.push_back(3'b101);
    for (int i = 7; i >= 0; i--)
      for (int k = 0; k < bc; k++) w.push_back({2'b10, c[i]});
    if (pe != 0)
      for (int k = 0; k < bc; k++) w.push_back({2'b10, ^c});
    for (int k = 0; k < gc; k++) w.push_back(3'b100);
    w.push_back(3'b010);
    foreach (w[j]) begin
      if (sel_b) exp_q_b.push_back(w[j]);
      else       exp_q_a.push_back(w[j]);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q_a.size() == 0 && exp_q_b.size() == 0) break;
      @(negedge clk);
    end
    n_vec++;
    assert (exp_q_a.size() == 0 && exp_q_b.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout left_a=%0d left_b=%0d want 0", exp_q_a.size(), exp_q_b.size());
    end
  endtask

  // Monitor: one comparison per DUT per cycle, 1ns after the rising edge.
  always @(posedge clk) begin
    logic [2:0] ea, eb;
    #1;
    ea = (exp_q_a.size() != 0) ? exp_q_a.pop_front() : 3'b000;
    eb = (exp_q_b.size() != 0) ? exp_q_b.pop_front() : 3'b000;
    n_vec++;
    assert ({busy_a, done_a, tx_a} === ea) else begin
      n_err++;
      $error("FAIL dut_a_line t=%0t busy/done/tx got %b want %b", $time, {busy_a, done_a, tx_a}, ea);
    end
    n_vec++;
    assert ({busy_b, done_b, tx_b} === eb) else begin
      n_err++;
      $error("FAIL dut_b_line t=%0t busy/done/tx got %b want %b", $time, {busy_b, done_b, tx_b}, eb);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // nominal frame A5 on A
    @(negedge clk); start_a = 1'b1; code = 8'hA5; push_frame(1'b0, 8'hA5);
    @(negedge clk); start_a = 1'b0; code = 8'h00;
    drain();

    // 07 on B, no parity slot
    @(negedge clk); start_b = 1'b1; code = 8'h07; push_frame(1'b1, 8'h07);
    @(negedge clk); start_b = 1'b0; code = 8'h00;
    drain();

    // parity bit set
    @(negedge clk); start_a = 1'b1; code = 8'h01; push_frame(1'b0, 8'h01);
    @(negedge clk); start_a = 1'b0; code = 8'h00;
    drain();

    // start while busy is ignored
    @(negedge clk); start_a = 1'b1; code = 8'hA5; push_frame(1'b0, 8'hA5);
    @(negedge clk); start_a = 1'b0;
    repeat (6) @(negedge clk);
    code = 8'hFF; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; code = 8'h00;
    drain();
    repeat (5) @(negedge clk);

    // abort during the 4th data bit, then restart
    @(negedge clk); start_a = 1'b1; code = 8'hA5; push_frame(1'b0, 8'hA5);
    @(negedge clk); start_a = 1'b0;
    repeat (8) @(negedge clk);
    abort = 1'b1; exp_q_a.delete();
    @(negedge clk); abort = 1'b0;
    start_a = 1'b1; code = 8'h3C; push_frame(1'b0, 8'h3C);
    @(negedge clk); start_a = 1'b0; code = 8'h00;
    drain();

    // reset mid-DATA: outputs clear without waiting for a clock
    @(negedge clk); start_a = 1'b1; code = 8'hA5; push_frame(1'b0, 8'hA5);
    @(negedge clk); start_a = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    exp_q_a.delete();
    reset_n = 1'b0;
    #1;
    n_vec++;
    assert ({busy_a, done_a, tx_a} === 3'b000) else begin
      n_err++;
      $error("FAIL async_reset busy/done/tx got %b want 000", {busy_a, done_a, tx_a});
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // continuous start: frames every N+1 cycles, done on each re-accept
    start_a = 1'b1; code = 8'h96;
    push_frame(1'b0, 8'h96); push_frame(1'b0, 8'h96); push_frame(1'b0, 8'h96);
    repeat (2 * (A_N + 1) + 5) @(negedge clk);
    start_a = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
